serial_adder_fsm: RTL and testbench

- Bit-serial WIDTH-bit adder that sits directly downstream of the team's gate primitive library.
- Datapath core is a 1-bit full-adder cell built only from library gates:
  - sum: 3-input XOR gate.
  - carry: three 2-input AND gates feeding a 3-input OR gate.
- Control FSM, operand shift registers and carry flop sequence the cell LSB-first over WIDTH cycles.
- Used as the arithmetic stage of the sequential-logic assignments; trades latency for minimal gate count.

---
 rtl/serial_adder_fsm_if.sv | 24 ++
 rtl/serial_adder_fsm.sv | 117 +++++++++++
 tb/tb_serial_adder_fsm.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_fsm_if.sv
// Handshake and operand/result bundle for serial_adder_fsm.
// master drives a request, slave (the adder) returns the result.
interface serial_adder_fsm_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, sub,
        input  ready, done, sum, cout
    );

    modport slave (
        input  start, a, b, sub,
        output ready, done, sum, cout
    );
endinterface

// File: rtl/serial_adder_fsm.sv
// Bit-serial WIDTH-bit adder: one gate-level full-adder cell sequenced LSB-first.
// Optional subtract mode is compiled in with SERIAL_ADDER_SUB_EN.
//
//   state  | meaning
//   IDLE   | ready=1, waiting for start
//   BUSY   | one sum bit per cycle, WIDTH cycles
//   DONE   | done=1 for one cycle, result held
module serial_adder_fsm #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    serial_adder_fsm_if.slave    bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_count;
    logic             r_carry;
    logic             r_cout;
    logic             r_ready;
    logic             r_done;

    logic             w_a_bit;
    logic             w_b_bit;
    logic             w_s;
    logic             w_and_ab;
    logic             w_and_ac;
    logic             w_and_bc;
    logic             w_maj;
    logic [WIDTH-1:0] w_b_load;
    logic             w_cin;

    // Full-adder cell: 3-input XOR for sum, three AND2 into an OR3 for carry.
    assign w_a_bit  = r_a_sh[0];
    assign w_b_bit  = r_b_sh[0];
    assign w_s      = w_a_bit ^ w_b_bit ^ r_carry;
    assign w_and_ab = w_a_bit & w_b_bit;
    assign w_and_ac = w_a_bit & r_carry;
    assign w_and_bc = w_b_bit & r_carry;
    assign w_maj    = w_and_ab | w_and_ac | w_and_bc;

`ifdef SERIAL_ADDER_SUB_EN
    // Two's-complement subtract: invert B and inject a carry-in of 1.
    assign w_b_load = bus.sub ? ~bus.b : bus.b;
    assign w_cin    = bus.sub;
`else
    // sub is ignored here; the AND with zero folds away entirely.
    assign w_b_load = bus.b;
    assign w_cin    = bus.sub & 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_sum   <= '0;
            r_count <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a_sh  <= bus.a;
                        r_b_sh  <= w_b_load;
                        r_count <= '0;
                        r_carry <= w_cin;
                        r_ready <= 1'b0;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_sum   <= {w_s, r_sum[WIDTH-1:1]};
                    r_carry <= w_maj;
                    r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_count <= r_count + CW'(1);
                    if (r_count == LAST_CNT) begin
                        r_cout  <= w_maj;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ready = r_ready;
    assign bus.done  = r_done;
    assign bus.sum   = r_sum;
    assign bus.cout  = r_cout;

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Directed self-checking bench for serial_adder_fsm at WIDTH=8.
module tb_serial_adder_fsm;
    localparam int W = 8;

    logic clk;
    logic reset_n;
    int   n_pass;
    int   n_checks;

    serial_adder_fsm_if #(.WIDTH(W)) bus ();

    serial_adder_fsm #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one operation and waits (bounded) for done; lat=-1 on timeout.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          output logic [W-1:0] s, output logic c, output int lat,
                          output logic rdy_err, output logic done_after);
        for (int i = 0; i < 20 && !bus.ready; i++) tick();
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.sub   = sub;
        tick();
        bus.start = 1'b0;
        bus.a     = ~a;
        bus.b     = ~b;
        bus.sub   = ~sub;
        lat       = -1;
        rdy_err   = 1'b0;
        s         = '0;
        c         = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (bus.ready) rdy_err = 1'b1;
            tick();
            if (bus.done) begin
                lat = i;
                s   = bus.sum;
                c   = bus.cout;
                if (bus.ready) rdy_err = 1'b1;
                break;
            end
        end
        tick();
        done_after = bus.done;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.sub   = 1'b0;
        #13;
        n_checks++; if (bus.ready !== 1'b1) $display("FAIL reset_ready got %b want 1", bus.ready); else n_pass++;
        n_checks++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else n_pass++;
        n_checks++; if (bus.sum !== 8'h00) $display("FAIL reset_sum got %h want 00", bus.sum); else n_pass++;
        n_checks++; if (bus.cout !== 1'b0) $display("FAIL reset_cout got %b want 0", bus.cout); else n_pass++;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_add_basic();
        logic [W-1:0] s; logic c; int lat; logic re; logic da;
        run_op(8'h5A, 8'h33, 1'b0, s, c, lat, re, da);
        n_checks++; if (s !== 8'h8D) $display("FAIL basic_sum got %h want 8d", s); else n_pass++;
        n_checks++; if (c !== 1'b0) $display("FAIL basic_cout got %b want 0", c); else n_pass++;
        n_checks++; if (lat !== 8) $display("FAIL basic_latency got %0d want 8", lat); else n_pass++;
        n_checks++; if (re !== 1'b0) $display("FAIL basic_ready_busy got %b want 0", re); else n_pass++;
        n_checks++; if (da !== 1'b0) $display("FAIL basic_done_width got %b want 0", da); else n_pass++;
        n_checks++; if (bus.ready !== 1'b1) $display("FAIL basic_ready_idle got %b want 1", bus.ready); else n_pass++;
        n_checks++; if (bus.sum !== 8'h8D) $display("FAIL basic_sum_hold got %h want 8d", bus.sum); else n_pass++;
    endtask

    task automatic test_carry();
        logic [W-1:0] s; logic c; int lat; logic re; logic da;
        run_op(8'hFF, 8'h01, 1'b0, s, c, lat, re, da);
        n_checks++; if (s !== 8'h00) $display("FAIL ovf_sum got %h want 00", s); else n_pass++;
        n_checks++; if (c !== 1'b1) $display("FAIL ovf_cout got %b want 1", c); else n_pass++;
        run_op(8'h00, 8'h00, 1'b0, s, c, lat, re, da);
        n_checks++; if (s !== 8'h00) $display("FAIL zero_sum got %h want 00", s); else n_pass++;
        n_checks++; if (c !== 1'b0) $display("FAIL zero_cout got %b want 0", c); else n_pass++;
        run_op(8'hA5, 8'h5B, 1'b0, s, c, lat, re, da);
        n_checks++; if (s !== 8'h00) $display("FAIL mixed_sum got %h want 00", s); else n_pass++;
        n_checks++; if (c !== 1'b1) $display("FAIL mixed_cout got %b want 1", c); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int last_i = 0;
        logic both = 1'b0;
        bus.start = 1'b1;
        bus.a     = 8'h01;
        bus.b     = 8'h02;
        bus.sub   = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.done && bus.ready) both = 1'b1;
            if (bus.done) begin
                pulses++;
                n_checks++; if (bus.sum !== 8'h03) $display("FAIL b2b_sum pulse %0d got %h want 03", pulses, bus.sum); else n_pass++;
                if (pulses == 1) begin
                    n_checks++; if (i !== 9) $display("FAIL b2b_first_done got cycle %0d want 9", i); else n_pass++;
                end else begin
                    n_checks++; if (i - last_i !== 10) $display("FAIL b2b_spacing got %0d want 10", i - last_i); else n_pass++;
                end
                last_i = i;
            end
            bus.a = bus.ready ? 8'h01 : 8'(($urandom_range(0, 255)));
        end
        bus.start = 1'b0;
        n_checks++; if (pulses !== 4) $display("FAIL b2b_pulse_count got %0d want 4", pulses); else n_pass++;
        n_checks++; if (both !== 1'b0) $display("FAIL b2b_done_and_ready got %b want 0", both); else n_pass++;
        tick();
        tick();
    endtask

    task automatic test_reset_abort();
        logic [W-1:0] s; logic c; int lat; logic re; logic da;
        logic stray = 1'b0;
        bus.start = 1'b1;
        bus.a     = 8'h80;
        bus.b     = 8'h80;
        bus.sub   = 1'b0;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        reset_n = 1'b0;
        #1;
        n_checks++; if (bus.ready !== 1'b1) $display("FAIL abort_ready got %b want 1", bus.ready); else n_pass++;
        n_checks++; if (bus.done !== 1'b0) $display("FAIL abort_done got %b want 0", bus.done); else n_pass++;
        n_checks++; if (bus.sum !== 8'h00) $display("FAIL abort_sum got %h want 00", bus.sum); else n_pass++;
        n_checks++; if (bus.cout !== 1'b0) $display("FAIL abort_cout got %b want 0", bus.cout); else n_pass++;
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done) stray = 1'b1;
        end
        n_checks++; if (stray !== 1'b0) $display("FAIL abort_stray_done got %b want 0", stray); else n_pass++;
        run_op(8'h12, 8'h34, 1'b0, s, c, lat, re, da);
        n_checks++; if (s !== 8'h46) $display("FAIL post_reset_sum got %h want 46", s); else n_pass++;
        n_checks++; if (c !== 1'b0) $display("FAIL post_reset_cout got %b want 0", c); else n_pass++;
        n_checks++; if (lat !== 8) $display("FAIL post_reset_latency got %0d want 8", lat); else n_pass++;
    endtask

    task automatic test_sub();
        logic [W-1:0] s; logic c; int lat; logic re; logic da;
`ifdef SERIAL_ADDER_SUB_EN
        run_op(8'h10, 8'h01, 1'b1, s, c, lat, re, da);
        n_checks++; if (s !== 8'h0F) $display("FAIL sub_sum got %h want 0f", s); else n_pass++;
        n_checks++; if (c !== 1'b1) $display("FAIL sub_cout got %b want 1", c); else n_pass++;
        run_op(8'h01, 8'h02, 1'b1, s, c, lat, re, da);
        n_checks++; if (s !== 8'hFF) $display("FAIL sub_borrow_sum got %h want ff", s); else n_pass++;
        n_checks++; if (c !== 1'b0) $display("FAIL sub_borrow_cout got %b want 0", c); else n_pass++;
`else
        run_op(8'h10, 8'h01, 1'b1, s, c, lat, re, da);
        n_checks++; if (s !== 8'h11) $display("FAIL sub_ignored_sum got %h want 11", s); else n_pass++;
        n_checks++; if (c !== 1'b0) $display("FAIL sub_ignored_cout got %b want 0", c); else n_pass++;
`endif
        run_op(8'h10, 8'h01, 1'b0, s, c, lat, re, da);
        n_checks++; if (s !== 8'h11) $display("FAIL add_mode_sum got %h want 11", s); else n_pass++;
    endtask

    initial begin
        n_pass   = 0;
        n_checks = 0;
        test_reset();
        test_add_basic();
        test_carry();
        test_back_to_back();
        test_reset_abort();
        test_sub();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
